// File: rtl/iop_writeback_if.sv
// Register-file write port bundle for iop_writeback.
//   master: drives wr_valid/wr_addr/wr_data, samples wr_ready (the writeback block)
//   slave : the shared register-file write port
interface iop_writeback_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_ready;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/iop_writeback.sv
// Writeback stage behind the integer-ops unit.
// Keeps the CF/OF/ZF flags register, aligns each writing op's destination with the
// integer-ops registered result (stage S1), muxes the result and queues {dst, data}
// in a small FIFO toward the register-file write port.
// Ports:
//   CLK, RST_N               clock, async active-low reset
//   issue_*                  issue strobe and op attributes from the sequencer
//   flag_cf/of/zf            combinational flags from integer-ops (issue cycle)
//   dout_select, dout1..3    integer-ops results (cycle after issue)
//   issue_ready              sequencer may issue a writing op this cycle
//   hz_addr, hazard          read-after-write check for a source register
//   wb                       register-file write port (valid/ready)
//   cf, of, zf               architectural flags
module iop_writeback #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  issue_en,
  input  logic                  issue_wr,
  input  logic [ADDR_WIDTH-1:0] issue_dst,
  input  logic                  issue_flags,
  input  logic                  flag_cf,
  input  logic                  flag_of,
  input  logic                  flag_zf,
  input  logic [1:0]            dout_select,
  input  logic [WIDTH-1:0]      dout1,
  input  logic [WIDTH-1:0]      dout2,
  input  logic [WIDTH-1:0]      dout3,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] hz_addr,
  output logic                  hazard,
  iop_writeback_if.master       wb,
  output logic                  cf,
  output logic                  of,
  output logic                  zf
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic                  cf_q, of_q, zf_q;
  logic                  s1_vld_q;
  logic [ADDR_WIDTH-1:0] s1_dst_q;
  logic [WIDTH-1:0]      s1_data;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]      data_q [DEPTH];
  ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
  logic [WIDTH-1:0]      head_data_q, head_data_d;
  logic                  push, pop;
  ptr_t                  hz_idx;

  // Conservative: a pop in this cycle is ignored, so the FIFO can never be pushed while full.
  assign issue_ready = (32'(cnt_q) + 32'(s1_vld_q)) < DEPTH;
  assign push        = s1_vld_q;
  assign pop         = vld_q & wb.wr_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_dst_q <= '0;
    end else begin
      if (issue_en && issue_flags) begin
        cf_q <= flag_cf;
        of_q <= flag_of;
        zf_q <= flag_zf;
      end
      // A writing op issued while not ready is dropped here.
      s1_vld_q <= issue_en & issue_wr & issue_ready;
      s1_dst_q <= issue_dst;
    end
  end

  always_comb begin
    s1_data = '0;
    if (s1_vld_q) begin
      case (dout_select)
        2'd1:    s1_data = dout1;
        2'd2:    s1_data = dout2;
        2'd3:    s1_data = dout3;
        default: s1_data = '0;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d       = cnt_q;
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    vld_d = (cnt_d != '0);
    // Head register mirrors the next head entry; the pushed entry becomes head only when
    // nothing else remains. When empty it keeps the last presented write.
    if (vld_d) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_addr_d = s1_dst_q;
        head_data_d = s1_data;
      end else begin
        head_addr_d = addr_q[rd_ptr_d];
        head_data_d = data_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      vld_q       <= 1'b0;
      head_addr_q <= '0;
      head_data_q <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= s1_dst_q;
        data_q[wr_ptr_q] <= s1_data;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      head_addr_q <= head_addr_d;
      head_data_q <= head_data_d;
    end
  end

  // Walk occupied entries from the read pointer; entries beyond cnt_q are stale.
  always_comb begin
    hazard = s1_vld_q && (s1_dst_q == hz_addr);
    hz_idx = rd_ptr_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((k < 32'(cnt_q)) && (addr_q[hz_idx] == hz_addr)) begin
        hazard = 1'b1;
      end
      hz_idx = ptr_inc(hz_idx);
    end
  end

  assign wb.wr_valid = vld_q;
  assign wb.wr_addr  = head_addr_q;
  assign wb.wr_data  = head_data_q;
  assign cf          = cf_q;
  assign of          = of_q;
  assign zf          = zf_q;

  // The sequencer must honour issue_ready for writing ops.
  a_issue_when_ready: assert property (
    @(posedge CLK) disable iff (!RST_N) !(issue_en && issue_wr && !issue_ready)
  ) else $error("iop_writeback: writing op issued while issue_ready=0");

endmodule

// File: tb/tb_iop_writeback.sv
module tb_iop_writeback;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic        wr;
    logic [5:0]  dst;
    logic [1:0]  sel;
    logic [15:0] d1, d2, d3;
    logic        fl, fcf, fof, fzf;
    logic [15:0] exp_data;
    logic        ecf, eof, ezf;
  } vec_t;

  logic        CLK, RST_N;
  logic        issue_en, issue_wr, issue_flags;
  logic [5:0]  issue_dst, hz_addr;
  logic        flag_cf, flag_of, flag_zf;
  logic [1:0]  dout_select;
  logic [15:0] dout1, dout2, dout3;
  logic        wr_ready;
  logic        sel4;

  logic ir2, hz2, cf2, of2, zf2;
  logic ir4, hz4, cf4, of4, zf4;
  logic en2, en4;

  logic        m_valid, m_ir, m_hz, m_cf, m_of, m_zf;
  logic [5:0]  m_addr;
  logic [15:0] m_data;

  int checks = 0;
  int errors = 0;
  wr_t sb_q[$];
  logic [15:0] pend_data = '0;
  vec_t vecs[6];

  iop_writeback_if #(.WIDTH(16), .ADDR_WIDTH(6)) wb2 ();
  iop_writeback_if #(.WIDTH(16), .ADDR_WIDTH(6)) wb4 ();

  assign en2 = issue_en & ~sel4;
  assign en4 = issue_en & sel4;
  assign wb2.wr_ready = wr_ready & ~sel4;
  assign wb4.wr_ready = wr_ready & sel4;

  iop_writeback #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(2)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .issue_en(en2), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .issue_flags(issue_flags), .flag_cf(flag_cf), .flag_of(flag_of), .flag_zf(flag_zf),
    .dout_select(dout_select), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .issue_ready(ir2), .hz_addr(hz_addr), .hazard(hz2), .wb(wb2.master),
    .cf(cf2), .of(of2), .zf(zf2)
  );

  iop_writeback #(.WIDTH(16), .ADDR_WIDTH(6), .DEPTH(4)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .issue_en(en4), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .issue_flags(issue_flags), .flag_cf(flag_cf), .flag_of(flag_of), .flag_zf(flag_zf),
    .dout_select(dout_select), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .issue_ready(ir4), .hz_addr(hz_addr), .hazard(hz4), .wb(wb4.master),
    .cf(cf4), .of(of4), .zf(zf4)
  );

  assign m_valid = sel4 ? wb4.wr_valid : wb2.wr_valid;
  assign m_addr  = sel4 ? wb4.wr_addr  : wb2.wr_addr;
  assign m_data  = sel4 ? wb4.wr_data  : wb2.wr_data;
  assign m_ir    = sel4 ? ir4 : ir2;
  assign m_hz    = sel4 ? hz4 : hz2;
  assign m_cf    = sel4 ? cf4 : cf2;
  assign m_of    = sel4 ? of4 : of2;
  assign m_zf    = sel4 ? zf4 : zf2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle: result of the previous writing op on dout1, optional new writing op.
  task automatic step(input logic en, input logic [5:0] dst, input logic [15:0] data);
    tick();
    issue_flags = 1'b0;
    dout_select = 2'd1;
    dout1       = pend_data;
    issue_en    = en;
    issue_wr    = en;
    issue_dst   = dst;
    if (en) begin
      sb_q.push_back('{addr: dst, data: data});
      pend_data = data;
    end
  endtask

  // Scoreboard: compare every completed handshake against the oldest expected write.
  always @(negedge CLK) begin
    if (RST_N && m_valid && wr_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", m_addr, m_data);
      end else begin
        wr_t exp;
        exp = sb_q.pop_front();
        if (m_addr !== exp.addr || m_data !== exp.data) begin
          errors++;
          $display("FAIL wr_order: got addr %0h data %0h expected addr %0h data %0h",
                   m_addr, m_data, exp.addr, exp.data);
        end
      end
    end
  end

  initial begin
    vecs[0] = '{1'b1, 6'd10, 2'd2, 16'h1111, 16'h00AB, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1,
                16'h00AB, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 6'd11, 2'd3, 16'h2222, 16'h00AB, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0,
                16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 6'd12, 2'd0, 16'h3333, 16'h00CD, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0,
                16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 6'd13, 2'd1, 16'hBEEF, 16'h0011, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b1,
                16'hBEEF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 6'd20, 2'd1, 16'hDEAD, 16'h0022, 16'h6666, 1'b1, 1'b1, 1'b1, 1'b1,
                16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 6'd14, 2'd2, 16'h7777, 16'h0055, 16'h8888, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0055, 1'b1, 1'b1, 1'b1};

    RST_N = 1'b0; sel4 = 1'b0; wr_ready = 1'b0; hz_addr = '0;
    issue_en = 1'b0; issue_wr = 1'b0; issue_dst = '0; issue_flags = 1'b0;
    flag_cf = 1'b0; flag_of = 1'b0; flag_zf = 1'b0;
    dout_select = '0; dout1 = '0; dout2 = '0; dout3 = '0;
    #1;
    chk("rst_valid2", 32'(wb2.wr_valid), 0);
    chk("rst_valid4", 32'(wb4.wr_valid), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_flags", {29'd0, m_cf, m_of, m_zf}, 0);
    chk("rst_ready", 32'(m_ir), 1);
    chk("rst_hazard", 32'(m_hz), 0);
    #11 RST_N = 1'b1;

    // Single write: two-cycle latency, valid for exactly one cycle.
    wr_ready = 1'b1;
    step(1'b1, 6'd5, 16'h1234);
    chk("single_c0_valid", 32'(m_valid), 0);
    step(1'b0, 6'd0, 16'h0);
    chk("single_c1_valid", 32'(m_valid), 0);
    step(1'b0, 6'd0, 16'h0);
    chk("single_c2_valid", 32'(m_valid), 1);
    chk("single_c2_addr", 32'(m_addr), 5);
    chk("single_c2_data", 32'(m_data), 32'h1234);
    step(1'b0, 6'd0, 16'h0);
    chk("single_c3_valid", 32'(m_valid), 0);
    chk("single_hold_addr", 32'(m_addr), 5);
    chk("single_hold_data", 32'(m_data), 32'h1234);

    // Table: back-to-back ops on DEPTH=4 covering mux selects and flag updates.
    sel4 = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i > 0) begin
        dout_select = vecs[i-1].sel;
        dout1 = vecs[i-1].d1;
        dout2 = vecs[i-1].d2;
        dout3 = vecs[i-1].d3;
        chk($sformatf("tbl%0d_flags", i - 1), {29'd0, m_cf, m_of, m_zf},
            {29'd0, vecs[i-1].ecf, vecs[i-1].eof, vecs[i-1].ezf});
      end
      if (i < 6) begin
        chk($sformatf("tbl%0d_ready", i), 32'(m_ir), 1);
        issue_en = 1'b1;
        issue_wr = vecs[i].wr;
        issue_dst = vecs[i].dst;
        issue_flags = vecs[i].fl;
        flag_cf = vecs[i].fcf;
        flag_of = vecs[i].fof;
        flag_zf = vecs[i].fzf;
        if (vecs[i].wr) sb_q.push_back('{addr: vecs[i].dst, data: vecs[i].exp_data});
      end else begin
        issue_en = 1'b0;
        issue_wr = 1'b0;
        issue_flags = 1'b0;
      end
    end
    repeat (4) step(1'b0, 6'd0, 16'h0);
    chk("tbl_drained", sb_q.size(), 0);

    // Backpressure on DEPTH=2.
    sel4 = 1'b0; wr_ready = 1'b0;
    step(1'b1, 6'd20, 16'h0A0A);
    step(1'b0, 6'd0, 16'h0);
    #1 chk("bp_c1_ready", 32'(m_ir), 1);
    issue_en = 1'b1; issue_wr = 1'b1; issue_dst = 6'd21;
    sb_q.push_back('{addr: 6'd21, data: 16'h0B0B});
    pend_data = 16'h0B0B;
    step(1'b0, 6'd0, 16'h0);
    #1 chk("bp_c2_ready", 32'(m_ir), 0);
    step(1'b0, 6'd0, 16'h0);
    chk("bp_c3_ready", 32'(m_ir), 0);
    chk("bp_c3_head", {10'd0, m_addr, m_data}, {10'd0, 6'd20, 16'h0A0A});
    step(1'b0, 6'd0, 16'h0);
    chk("bp_c4_stable", {9'd0, m_valid, m_addr, m_data}, {9'd0, 1'b1, 6'd20, 16'h0A0A});
    wr_ready = 1'b1;
    #1 chk("bp_c4_ready_pop", 32'(m_ir), 0);
    step(1'b0, 6'd0, 16'h0);
    wr_ready = 1'b0;
    #1 chk("bp_c5_ready", 32'(m_ir), 1);
    chk("bp_c5_head", {10'd0, m_addr, m_data}, {10'd0, 6'd21, 16'h0B0B});
    wr_ready = 1'b1;
    step(1'b0, 6'd0, 16'h0);
    step(1'b0, 6'd0, 16'h0);
    chk("bp_c7_empty", 32'(m_valid), 0);
    chk("bp_drained", sb_q.size(), 0);

    // Pointer wrap on DEPTH=4 (write pointer starts at slot 1 after the table).
    sel4 = 1'b1; wr_ready = 1'b0;
    step(1'b1, 6'd40, 16'h4040);
    step(1'b1, 6'd41, 16'h4141);
    step(1'b1, 6'd42, 16'h4242);
    step(1'b1, 6'd43, 16'h4343);
    step(1'b0, 6'd0, 16'h0);
    #1 chk("wrap_full_ready", 32'(m_ir), 0);
    step(1'b0, 6'd0, 16'h0);
    chk("wrap_c5_ready", 32'(m_ir), 0);
    chk("wrap_c5_head", {10'd0, m_addr, m_data}, {10'd0, 6'd40, 16'h4040});
    wr_ready = 1'b1;
    step(1'b0, 6'd0, 16'h0);
    wr_ready = 1'b0;
    #1 chk("wrap_c6_ready", 32'(m_ir), 1);
    step(1'b1, 6'd44, 16'h4444);
    step(1'b0, 6'd0, 16'h0);
    wr_ready = 1'b1;
    repeat (8) step(1'b0, 6'd0, 16'h0);
    chk("wrap_drained", sb_q.size(), 0);

    // Hazard on DEPTH=2.
    sel4 = 1'b0; wr_ready = 1'b0;
    step(1'b1, 6'd9, 16'h0909);
    step(1'b0, 6'd0, 16'h0);
    hz_addr = 6'd9;
    #1 chk("hz_s1_match", 32'(m_hz), 1);
    step(1'b0, 6'd0, 16'h0);
    #1 chk("hz_fifo_match", 32'(m_hz), 1);
    hz_addr = 6'd8;
    #1 chk("hz_fifo_nomatch", 32'(m_hz), 0);
    hz_addr = 6'd9;
    wr_ready = 1'b1;
    #1 chk("hz_handshake_cycle", 32'(m_hz), 1);
    step(1'b0, 6'd0, 16'h0);
    wr_ready = 1'b0;
    #1 chk("hz_released", 32'(m_hz), 0);

    // Reset mid-operation with two queued writes.
    step(1'b1, 6'd30, 16'h3030);
    issue_flags = 1'b1; flag_cf = 1'b1; flag_of = 1'b1; flag_zf = 1'b1;
    step(1'b1, 6'd31, 16'h3131);
    step(1'b0, 6'd0, 16'h0);
    step(1'b0, 6'd0, 16'h0);
    chk("rmid_valid_before", 32'(m_valid), 1);
    chk("rmid_flags_before", {29'd0, m_cf, m_of, m_zf}, 32'h7);
    #2 RST_N = 1'b0;
    #1;
    chk("rmid_valid_async", 32'(m_valid), 0);
    chk("rmid_flags_async", {29'd0, m_cf, m_of, m_zf}, 0);
    chk("rmid_head_async", {10'd0, m_addr, m_data}, 0);
    sb_q.delete();
    wr_ready = 1'b1;
    @(negedge CLK);
    #1 RST_N = 1'b1;
    #1 chk("rmid_ready_after", 32'(m_ir), 1);
    repeat (5) step(1'b0, 6'd0, 16'h0);
    chk("rmid_no_stale", 32'(m_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
